datapath_arbiter: RTL and testbench
===================================

// Module: datapath_arbiter
// PURPOSE
//  Round-robin arbiter and sequencer sharing one Datapath instance among NUM_REQ requesters
//  (e.g. network evaluator, renderer, genome loader). It sits between the requesters and
//  the Datapath start/instruction/finished/result interface. It issues one instruction
//  at a time and returns the Datapath result to the requester that issued it.
// PARAMETERS
//  NUM_REQ   4                    number of requesters, 2..8
//  INSTR_W   `INSTRUCTION_WIDTH   instruction width; opcode in the top `OPCODE_WIDTH bits
//  RESULT_W  `RESULT_WIDTH        result width
// PORTS
//  clock            in   1                  single clock, rising edge
//  reset            in   1                  synchronous, active-high
//  req              in   NUM_REQ            req[i]: requester i has an instruction pending
//  req_instruction  in   NUM_REQ*INSTR_W    slice i = instruction of requester i
//  grant            out  NUM_REQ            one-hot; bit i set from ISSUE through RESPOND
//  done             out  NUM_REQ            1-cycle pulse to the owner when its op completes
//  result           out  RESULT_W           result of the last completed op; valid while done!=0 and held after
//  busy             out  1                  high whenever state != IDLE
//  dp_start         out  1                  Datapath start strobe
//  dp_instruction   out  INSTR_W            instruction presented to the Datapath
//  dp_finished      in   1                  Datapath finished flag
//  dp_result        in   RESULT_W           Datapath result
// BEHAVIOUR
//  - Reset values: state=IDLE; grant=0; done=0; result=0; busy=0; dp_start=0;
//    dp_instruction=0; rr_ptr=NUM_REQ-1, so req[0] wins first.
//  - FSM states: IDLE -> ISSUE -> WAIT_BUSY -> WAIT_DONE -> RESPOND -> IDLE. All outputs are registered.
//  - IDLE: if |req and dp_finished, pick winner w. Latch instruction slice w into dp_instruction,
//    set grant=1<<w and go to ISSUE. Otherwise stay in IDLE.
//  - ISSUE: dp_start=1 for exactly this cycle, then go to WAIT_BUSY.
//  - WAIT_BUSY: wait for dp_finished==0, then go to WAIT_DONE. This covers the Datapath's
//    1-cycle finished update; it must not mistake the stale finished=1 for completion.
//  - WAIT_DONE: on dp_finished==1, register result<=dp_result and go to RESPOND.
//  - RESPOND: done[w]=1 for one cycle, grant cleared at the end of the cycle, rr_ptr<=w, then IDLE.
//  - Latency: minimum of 5 cycles from req sampled in IDLE to the done pulse for an unknown
//    opcode (Datapath finishes immediately). Opcodes 1/2/3 add their own Datapath delay.
//    At least one IDLE cycle separates consecutive operations.
//  - Round-robin: search starts at (rr_ptr+1) mod NUM_REQ and wraps; the first asserted req wins.
//  - Requester rule: hold req and its instruction until done. req still high in IDLE after
//    done is a new request. Deasserting req mid-operation is ignored: the op completes and done still pulses.
//  - dp_instruction is held constant from ISSUE through RESPOND.
//  - Simultaneous requests are resolved in a single IDLE cycle; the others wait and are not dropped.
//  - Reset mid-operation: the FSM returns to IDLE and no done is pulsed. The Datapath shares the
//    system reset, so no op is left in flight.
// CONFIGURATION
//  DP_ARB_FIXED_PRIORITY_EN
//   defined: fixed priority, lowest index wins; rr_ptr is unused.
//   undefined (default): round-robin as above.
// TESTING
//  1 Single req[2], instr opcode 2 with addr 0x0010, mem returns 0xABC -> one dp_start;
//    done=4'b0100 pulse; result=0xABC held after.
//  2 req=4'b1111 held after reset -> grant order 0,1,2,3,0; exactly one grant bit at a time.
//  3 req[1] dropped one cycle after ISSUE (opcode 1 plot) -> op completes; done[1] still pulses.
//  4 Default opcode 0 -> done pulses exactly 5 cycles after req sampled; Datapath sees one start.
//  5 reset asserted during WAIT_DONE -> next cycle: grant=0, busy=0, dp_start=0, no done pulse.
//  6 With DP_ARB_FIXED_PRIORITY_EN, req=4'b1010 held -> req[1] always granted and req[3] starved;
//    without it, grants alternate 1,3,1.

Source files
------------

// File: rtl/datapath_arbiter.sv
// Round-robin arbiter/sequencer sharing one Datapath among NUM_REQ requesters.
// Define DP_ARB_FIXED_PRIORITY_EN for fixed lowest-index-wins priority instead of round-robin.
`ifndef INSTRUCTION_WIDTH
`define INSTRUCTION_WIDTH 16
`endif
`ifndef OPCODE_WIDTH
`define OPCODE_WIDTH 4
`endif
`ifndef RESULT_WIDTH
`define RESULT_WIDTH 16
`endif

module datapath_arbiter #(
    parameter int NUM_REQ  = 4,
    parameter int INSTR_W  = `INSTRUCTION_WIDTH,
    parameter int RESULT_W = `RESULT_WIDTH
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*INSTR_W-1:0] req_instruction,
    output logic [NUM_REQ-1:0]         grant,
    output logic [NUM_REQ-1:0]         done,
    output logic [RESULT_W-1:0]        result,
    output logic                       busy,
    output logic                       dp_start,
    output logic [INSTR_W-1:0]         dp_instruction,
    input  logic                       dp_finished,
    input  logic [RESULT_W-1:0]        dp_result
);

    localparam int PTR_W = $clog2(NUM_REQ);

    typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, RESPOND} state_t;

    state_t               state, state_next;
    logic [PTR_W-1:0]     winner, idx;
    logic                 found;
    logic [INSTR_W-1:0]   win_instr;
    logic [NUM_REQ-1:0]   grant_next, done_next;
    logic [RESULT_W-1:0]  result_next;
    logic                 busy_next, start_next;
    logic [INSTR_W-1:0]   instr_next;

`ifdef DP_ARB_FIXED_PRIORITY_EN
    // Descending scan so the lowest asserted index is the last (winning) assignment.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = PTR_W'(k);
            if (req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end
`else
    logic [PTR_W-1:0] rr_ptr, rr_ptr_next, owner, owner_next;

    // Search starts just after the last served requester and wraps around.
    always_comb begin
        winner = '0;
        found  = 1'b0;
        idx    = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            idx = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
            if (!found && req[idx]) begin
                found  = 1'b1;
                winner = idx;
            end
        end
    end
`endif

    always_comb begin
        win_instr = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (winner == PTR_W'(k)) win_instr = req_instruction[k*INSTR_W +: INSTR_W];
        end
    end

    always_comb begin
        state_next  = state;
        grant_next  = grant;
        done_next   = '0;
        result_next = result;
        start_next  = 1'b0;
        instr_next  = dp_instruction;
`ifndef DP_ARB_FIXED_PRIORITY_EN
        owner_next  = owner;
        rr_ptr_next = rr_ptr;
`endif
        case (state)
            IDLE: begin
                if (found && dp_finished) begin
                    state_next = ISSUE;
                    grant_next = NUM_REQ'(1) << winner;
                    instr_next = win_instr;
                    start_next = 1'b1;
`ifndef DP_ARB_FIXED_PRIORITY_EN
                    owner_next = winner;
`endif
                end
            end
            ISSUE:     state_next = WAIT_BUSY;
            // The Datapath's finished flag lags the start strobe; wait for it to drop first.
            WAIT_BUSY: if (!dp_finished) state_next = WAIT_DONE;
            WAIT_DONE: begin
                if (dp_finished) begin
                    state_next  = RESPOND;
                    result_next = dp_result;
                    done_next   = grant;
                end
            end
            RESPOND: begin
                state_next = IDLE;
                grant_next = '0;
`ifndef DP_ARB_FIXED_PRIORITY_EN
                rr_ptr_next = owner;
`endif
            end
            default: state_next = IDLE;
        endcase
        busy_next = (state_next != IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= IDLE;
            grant          <= '0;
            done           <= '0;
            result         <= '0;
            busy           <= 1'b0;
            dp_start       <= 1'b0;
            dp_instruction <= '0;
`ifndef DP_ARB_FIXED_PRIORITY_EN
            rr_ptr         <= PTR_W'(NUM_REQ - 1);
            owner          <= '0;
`endif
        end else begin
            state          <= state_next;
            grant          <= grant_next;
            done           <= done_next;
            result         <= result_next;
            busy           <= busy_next;
            dp_start       <= start_next;
            dp_instruction <= instr_next;
`ifndef DP_ARB_FIXED_PRIORITY_EN
            rr_ptr         <= rr_ptr_next;
            owner          <= owner_next;
`endif
        end
    end

endmodule

// File: tb/tb_datapath_arbiter.sv
// Directed testbench for datapath_arbiter with a small behavioural Datapath model.
// Opcode delays: 1->2, 2->3, 3->1, other->0 extra cycles; opcode 2 returns 0x0AAC+addr, others instr^0x5A5A.
module tb_datapath_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic [63:0] req_instruction;
    logic [3:0]  grant, done;
    logic [15:0] result;
    logic        busy, dp_start;
    logic [15:0] dp_instruction;
    logic        dp_finished;
    logic [15:0] dp_result;

    int compared   = 0;
    int mismatched = 0;
    int starts     = 0;
    int onehot_viol = 0;

    logic        dp_pending, dp_active;
    logic [3:0]  dp_cnt;
    logic [15:0] dp_latched;

    datapath_arbiter #(.NUM_REQ(4), .INSTR_W(16), .RESULT_W(16)) dut (
        .clock(clock), .reset(reset), .req(req), .req_instruction(req_instruction),
        .grant(grant), .done(done), .result(result), .busy(busy),
        .dp_start(dp_start), .dp_instruction(dp_instruction),
        .dp_finished(dp_finished), .dp_result(dp_result)
    );

    always #5 clock = ~clock;

    // Datapath model: finished drops one cycle after start is seen, then rises after the opcode delay.
    always @(posedge clock) begin
        if (reset) begin
            dp_finished <= 1'b1; dp_pending <= 1'b0; dp_active <= 1'b0;
            dp_cnt <= '0; dp_result <= '0; dp_latched <= '0;
        end else begin
            if (dp_start) begin
                dp_pending <= 1'b1; dp_latched <= dp_instruction; starts <= starts + 1;
            end
            if (dp_pending) begin
                dp_pending <= 1'b0; dp_finished <= 1'b0; dp_active <= 1'b1;
                case (dp_latched[15:12])
                    4'd1:    dp_cnt <= 4'd2;
                    4'd2:    dp_cnt <= 4'd3;
                    4'd3:    dp_cnt <= 4'd1;
                    default: dp_cnt <= 4'd0;
                endcase
            end else if (dp_active) begin
                if (dp_cnt == 0) begin
                    dp_finished <= 1'b1; dp_active <= 1'b0;
                    dp_result <= (dp_latched[15:12] == 4'd2) ? 16'h0AAC + {4'h0, dp_latched[11:0]}
                                                             : dp_latched ^ 16'h5A5A;
                end else dp_cnt <= dp_cnt - 4'd1;
            end
        end
    end

    always @(negedge clock) if (!reset && $countones(grant) > 1) onehot_viol++;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "[TB] watchdog");
    end

    task automatic do_reset;
        reset = 1'b1; req = '0; req_instruction = '0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic wait_done(output logic [3:0] d, output bit ok);
        ok = 1'b0; d = '0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clock);
            if (done !== 4'b0000) begin d = done; ok = 1'b1; return; end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; req = 4'b1111; req_instruction = 64'h0003_0002_0001_0000;
        repeat (2) @(negedge clock);
        compared++; if (grant !== 4'b0) begin mismatched++; $display("[TB] FAIL reset_grant: got %b expected 0000", grant); end
        compared++; if (done !== 4'b0) begin mismatched++; $display("[TB] FAIL reset_done: got %b expected 0000", done); end
        compared++; if (result !== 16'h0) begin mismatched++; $display("[TB] FAIL reset_result: got %h expected 0000", result); end
        compared++; if (busy !== 1'b0 || dp_start !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_busy_start: got %b%b expected 00", busy, dp_start); end
        compared++; if (dp_instruction !== 16'h0) begin mismatched++; $display("[TB] FAIL reset_instr: got %h expected 0000", dp_instruction); end
        req = '0; reset = 1'b0;
        @(negedge clock);
    endtask

    task automatic test_single;
        logic [3:0] d; bit ok; int s0;
        s0 = starts;
        req_instruction[47:32] = 16'h2010; req = 4'b0100;
        wait_done(d, ok);
        compared++; if (!ok) begin mismatched++; $display("[TB] FAIL single_timeout: got none expected done"); end
        compared++; if (d !== 4'b0100) begin mismatched++; $display("[TB] FAIL single_done: got %b expected 0100", d); end
        compared++; if (grant !== 4'b0100) begin mismatched++; $display("[TB] FAIL single_grant: got %b expected 0100", grant); end
        compared++; if (result !== 16'h0ABC) begin mismatched++; $display("[TB] FAIL single_result: got %h expected 0abc", result); end
        compared++; if (dp_instruction !== 16'h2010) begin mismatched++; $display("[TB] FAIL single_instr: got %h expected 2010", dp_instruction); end
        req = '0;
        @(negedge clock);
        compared++; if (done !== 4'b0 || grant !== 4'b0 || busy !== 1'b0) begin mismatched++; $display("[TB] FAIL single_after: got done=%b grant=%b busy=%b expected 0000 0000 0", done, grant, busy); end
        repeat (3) @(negedge clock);
        compared++; if (result !== 16'h0ABC) begin mismatched++; $display("[TB] FAIL single_held: got %h expected 0abc", result); end
        compared++; if (starts - s0 !== 1) begin mismatched++; $display("[TB] FAIL single_starts: got %0d expected 1", starts - s0); end
    endtask

    task automatic test_round_robin;
        logic [3:0] d; bit ok;
        logic [3:0] exp_order [5];
`ifdef DP_ARB_FIXED_PRIORITY_EN
        exp_order = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
        exp_order = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
        do_reset();
        onehot_viol = 0;
        req_instruction = 64'h0103_0102_0101_0100; req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_done(d, ok);
            compared++; if (!ok || d !== exp_order[i]) begin mismatched++; $display("[TB] FAIL rr_order[%0d]: got %b expected %b", i, d, exp_order[i]); end
        end
        req = '0;
        repeat (2) @(negedge clock);
        compared++; if (onehot_viol !== 0) begin mismatched++; $display("[TB] FAIL rr_onehot: got %0d violations expected 0", onehot_viol); end
    endtask

    task automatic test_drop;
        logic [3:0] d; bit ok; bit seen;
        req_instruction[31:16] = 16'h1005; req = 4'b0010;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clock);
            if (dp_start === 1'b1) seen = 1'b1;
        end
        compared++; if (!seen) begin mismatched++; $display("[TB] FAIL drop_issue: got no start expected start"); end
        @(negedge clock);
        req = '0;
        wait_done(d, ok);
        compared++; if (!ok || d !== 4'b0010) begin mismatched++; $display("[TB] FAIL drop_done: got %b expected 0010", d); end
        compared++; if (result !== 16'h4A5F) begin mismatched++; $display("[TB] FAIL drop_result: got %h expected 4a5f", result); end
        repeat (2) @(negedge clock);
    endtask

    task automatic test_latency;
        int n; int s0;
        s0 = starts; n = 0;
        req_instruction[63:48] = 16'h0123; req = 4'b1000;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock); n++;
            if (done !== 4'b0) break;
        end
        compared++; if (n !== 5) begin mismatched++; $display("[TB] FAIL latency_cycles: got %0d expected 5", n); end
        compared++; if (done !== 4'b1000) begin mismatched++; $display("[TB] FAIL latency_done: got %b expected 1000", done); end
        compared++; if (result !== 16'h5B79) begin mismatched++; $display("[TB] FAIL latency_result: got %h expected 5b79", result); end
        req = '0;
        repeat (3) @(negedge clock);
        compared++; if (starts - s0 !== 1) begin mismatched++; $display("[TB] FAIL latency_starts: got %0d expected 1", starts - s0); end
    endtask

    task automatic test_reset_mid;
        bit seen; int pulses;
        req_instruction[15:0] = 16'h2020; req = 4'b0001;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clock);
            if (dp_finished === 1'b0) seen = 1'b1;
        end
        @(negedge clock);
        compared++; if (!seen || busy !== 1'b1 || grant !== 4'b0001) begin mismatched++; $display("[TB] FAIL midreset_pre: got busy=%b grant=%b expected 1 0001", busy, grant); end
        reset = 1'b1; req = '0;
        @(negedge clock);
        compared++; if (grant !== 4'b0 || busy !== 1'b0 || dp_start !== 1'b0 || done !== 4'b0) begin mismatched++; $display("[TB] FAIL midreset_post: got grant=%b busy=%b start=%b done=%b expected 0000 0 0 0000", grant, busy, dp_start, done); end
        reset = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clock);
            if (done !== 4'b0) pulses++;
        end
        compared++; if (pulses !== 0) begin mismatched++; $display("[TB] FAIL midreset_nodone: got %0d pulses expected 0", pulses); end
    endtask

    task automatic test_priority;
        logic [3:0] d; bit ok;
        logic [3:0] exp_order [3];
`ifdef DP_ARB_FIXED_PRIORITY_EN
        exp_order = '{4'b0010, 4'b0010, 4'b0010};
`else
        exp_order = '{4'b0010, 4'b1000, 4'b0010};
`endif
        do_reset();
        req_instruction = 64'h0333_0000_0111_0000; req = 4'b1010;
        for (int i = 0; i < 3; i++) begin
            wait_done(d, ok);
            compared++; if (!ok || d !== exp_order[i]) begin mismatched++; $display("[TB] FAIL prio_order[%0d]: got %b expected %b", i, d, exp_order[i]); end
        end
        req = '0;
        repeat (2) @(negedge clock);
    endtask

    initial begin
        reset = 1'b1; req = '0; req_instruction = '0;
        test_reset();
        test_single();
        test_round_robin();
        test_drop();
        test_latency();
        test_reset_mid();
        test_priority();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
